// File: rtl/apb_master_bridge_if.sv
// Core request/response and APB3 signal bundle for apb_master_bridge.
// The master modport is the bridge's view; slave is the opposite view for a peer model.
interface apb_master_bridge_if #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32
);
    logic                      req_i;
    logic                      gnt_o;
    logic                      we_i;
    logic [APB_ADDR_WIDTH-1:0] addr_i;
    logic [APB_DATA_WIDTH-1:0] wdata_i;
    logic                      rvalid_o;
    logic [APB_DATA_WIDTH-1:0] rdata_o;
    logic                      err_o;

    logic [APB_ADDR_WIDTH-1:0] paddr_o;
    logic [APB_DATA_WIDTH-1:0] pwdata_o;
    logic                      pwrite_o;
    logic                      psel_o;
    logic                      penable_o;
    logic [APB_DATA_WIDTH-1:0] prdata_i;
    logic                      pready_i;
    logic                      pslverr_i;

    modport master (
        input  req_i, we_i, addr_i, wdata_i, prdata_i, pready_i, pslverr_i,
        output gnt_o, rvalid_o, rdata_o, err_o,
               paddr_o, pwdata_o, pwrite_o, psel_o, penable_o
    );

    modport slave (
        output req_i, we_i, addr_i, wdata_i, prdata_i, pready_i, pslverr_i,
        input  gnt_o, rvalid_o, rdata_o, err_o,
               paddr_o, pwdata_o, pwrite_o, psel_o, penable_o
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding req/gnt/rvalid to APB3 initiator (SETUP then ACCESS).
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS with an error after TIMEOUT_CYCLES wait states.
module apb_master_bridge #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic                 clk_i,
    input logic                 rst_i,
    apb_master_bridge_if.master bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_master_bridge: TIMEOUT_CYCLES must be >= 1");
    end

    logic [1:0]                state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                      pwrite_q, pwrite_d;
    logic                      rvalid_q, rvalid_d;
    logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      err_q, err_d;
    logic                      timeout;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] waitCnt_q, waitCnt_d;

    // Counter holds the number of wait states already seen in this ACCESS phase.
    always_comb begin
        waitCnt_d = waitCnt_q;
        if (state_q == SETUP) begin
            waitCnt_d = '0;
        end else if (state_q == ACCESS && !bus.pready_i) begin
            waitCnt_d = waitCnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            waitCnt_q <= '0;
        end else begin
            waitCnt_q <= waitCnt_d;
        end
    end

    assign timeout = (waitCnt_q == CNT_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_i) begin
                    paddr_d  = bus.addr_i;
                    pwdata_d = bus.wdata_i;
                    pwrite_d = bus.we_i;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // A ready slave takes priority over an expiring wait budget.
                if (bus.pready_i) begin
                    state_d  = IDLE;
                    rvalid_d = 1'b1;
                    err_d    = bus.pslverr_i;
                    rdata_d  = pwrite_q ? '0 : bus.prdata_i;
                end else if (timeout) begin
                    state_d  = IDLE;
                    rvalid_d = 1'b1;
                    err_d    = 1'b1;
                    rdata_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // APB strobes decode straight from state so a reset drops them without waiting for a clock.
    assign bus.gnt_o     = (state_q == IDLE) && bus.req_i;
    assign bus.psel_o    = (state_q == SETUP) || (state_q == ACCESS);
    assign bus.penable_o = (state_q == ACCESS);
    assign bus.paddr_o   = paddr_q;
    assign bus.pwdata_o  = pwdata_q;
    assign bus.pwrite_o  = pwrite_q;
    assign bus.rvalid_o  = rvalid_q;
    assign bus.rdata_o   = rdata_q;
    assign bus.err_o     = err_q;

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
Single-outstanding APB initiator that turns a simple req/gnt/rvalid core-side request interface into APB3 transfers (SETUP then ACCESS phase). It is the upstream counterpart of the APB node: its APB outputs drive a node slave port or an APB peripheral directly. It is used by DMA-less controllers and debug logic to reach the peripheral subsystem.

Parameters:
APB_ADDR_WIDTH, 32, width of addr_i and paddr_o
APB_DATA_WIDTH, 32, width of wdata_i, rdata_o, pwdata_o and prdata_i
TIMEOUT_CYCLES, 256, ACCESS-phase wait-state limit; used only with APB_MASTER_TIMEOUT_EN; must be >= 1

Ports:
clk_i  in  1  clock; all state on rising edge
rst_i  in  1  asynchronous reset, active-high
req_i  in  1  core request valid
gnt_o  out  1  request accepted this cycle
we_i  in  1  1 = write, 0 = read
addr_i  in  APB_ADDR_WIDTH  request address
wdata_i  in  APB_DATA_WIDTH  write data
rvalid_o  out  1  one-cycle response strobe
rdata_o  out  APB_DATA_WIDTH  read data, valid with rvalid_o
err_o  out  1  error flag, valid with rvalid_o
paddr_o  out  APB_ADDR_WIDTH  APB address
pwdata_o  out  APB_DATA_WIDTH  APB write data
pwrite_o  out  1  APB direction
psel_o  out  1  APB select
penable_o  out  1  APB enable
prdata_i  in  APB_DATA_WIDTH  APB read data
pready_i  in  1  APB ready
pslverr_i  in  1  APB slave error

Behaviour:
- Clock clk_i; reset is asynchronous and active-high on rst_i.
- Reset: state IDLE; psel_o, penable_o, pwrite_o, rvalid_o, err_o = 0; paddr_o, pwdata_o, rdata_o = 0.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - gnt_o = req_i (combinational). gnt_o is 0 in all other states.
  - On req_i && gnt_o: register addr_i, wdata_i and we_i into paddr_o, pwdata_o and pwrite_o; next state SETUP.
  - psel_o = 0, penable_o = 0.
- SETUP: psel_o = 1, penable_o = 0, exactly one cycle; then ACCESS.
- ACCESS:
  - psel_o = 1, penable_o = 1.
  - Stay in ACCESS while pready_i = 0.
  - On pready_i = 1: next state IDLE. Register the response:
    - rvalid_o = 1 in the following cycle.
    - err_o = pslverr_i.
    - rdata_o = prdata_i for a read, 0 for a write.
- pslverr_i and prdata_i are sampled only in ACCESS with pready_i = 1; they are ignored at all other times.
- paddr_o, pwdata_o and pwrite_o stay stable from SETUP until the next grant. They are not cleared on return to IDLE.
- rvalid_o is a one-cycle pulse. rdata_o and err_o hold their values until the next response.
- Latency: grant at cycle T gives SETUP at T+1, ACCESS at T+2, rvalid_o at T+3 with zero wait states. Each wait state adds one cycle.
- Back-to-back: a new grant is possible in the same IDLE cycle in which rvalid_o is high, giving a minimum of 3 cycles per transfer.
- No request queuing: req_i outside IDLE is ignored until IDLE; the requester holds req_i.
- Reset mid-transfer: psel_o and penable_o drop immediately (asynchronous); no rvalid_o is issued for the aborted transfer.

Optional Feature:
APB_MASTER_TIMEOUT_EN
- Defined:
  - A wait counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS and increments each ACCESS cycle with pready_i = 0.
  - If the counter reaches TIMEOUT_CYCLES while pready_i = 0, the transfer aborts: next state IDLE, then rvalid_o = 1, err_o = 1, rdata_o = 0.
  - pready_i = 1 in the same cycle wins over the timeout.
- Undefined: no counter; ACCESS waits for pready_i indefinitely.

Test Plan:
- Write, no wait states: req with we=1, addr=0x1A10_0004, wdata=0xDEAD_BEEF -> gnt same cycle; SETUP with psel=1, penable=0, paddr=0x1A10_0004, pwdata=0xDEAD_BEEF, pwrite=1; ACCESS one cycle; rvalid 3 cycles after grant, err=0, rdata=0.
- Read with 2 wait states: slave returns prdata=0x0000_00A5 on the 3rd ACCESS cycle -> rvalid 5 cycles after grant, rdata=0x0000_00A5, err=0; paddr stable throughout.
- Slave error: read with pslverr=1 and prdata=0x1234 at pready -> rvalid=1, err=1, rdata=0x1234.
- Back-to-back: req held for 3 requests, zero wait states -> grants at T, T+3, T+6; each rvalid coincides with the next grant; psel low exactly one cycle between transfers.
- Reset mid-ACCESS: rst_i pulsed while pready=0 -> psel=penable=0 asynchronously; no rvalid; the next request proceeds normally.
- Timeout (APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4): pready held 0 -> abort after 4 ACCESS cycles, rvalid=1, err=1, rdata=0; without the macro the bridge stays in ACCESS for more than 100 cycles.
